// File: rtl/led_pwm_bank_if.sv
// rtl/led_pwm_bank_if.sv - write port bundle for the LED PWM bank
interface led_pwm_bank_if #(
    parameter int N_LEDS   = 5,
    parameter int PWM_BITS = 8
);
    localparam int CH_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic [1:0]          wr_mode;
    logic [PWM_BITS-1:0] wr_duty;

    modport master (output wr_en, wr_ch, wr_mode, wr_duty);
    modport slave  (input  wr_en, wr_ch, wr_mode, wr_duty);
endinterface

// File: rtl/led_pwm_bank.sv
// rtl/led_pwm_bank.sv - multi-channel LED PWM driver (breathe ramp under LED_BREATHE_EN)
module led_pwm_bank #(
    parameter int N_LEDS        = 5,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 47,
    parameter int BLINK_PERIODS = 122
) (
    input  logic                clk,
    input  logic                rst,
    led_pwm_bank_if.slave       wr,
    output logic [N_LEDS-1:0]   led,
    output logic                period_start
);
    localparam int PRE_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    logic [PRE_W-1:0]    pre_cnt;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                boundary;
    logic [BLK_W-1:0]    blink_cnt;
    logic                blink_phase;

    mode_t               sh_mode  [N_LEDS];
    logic [PWM_BITS-1:0] sh_duty  [N_LEDS];
    mode_t               act_mode [N_LEDS];
    logic [PWM_BITS-1:0] act_duty [N_LEDS];
    logic [PWM_BITS-1:0] eff      [N_LEDS];

    assign tick     = (pre_cnt == PRE_W'(PRESCALE));
    assign boundary = tick && (pwm_cnt == DUTY_MAX);

    // Shared prescaler and free-running PWM counter; the counter wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            if (tick) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    // Shadow registers take writes any time; out-of-range channels are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LEDS; i++) begin
                sh_mode[i] <= MODE_OFF;
                sh_duty[i] <= '0;
            end
        end else if (wr.wr_en && (int'(wr.wr_ch) < N_LEDS)) begin
            sh_mode[wr.wr_ch] <= mode_t'(wr.wr_mode);
            sh_duty[wr.wr_ch] <= wr.wr_duty;
        end
    end

    // Active settings copy the pre-write shadow only at the period boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LEDS; i++) begin
                act_mode[i] <= MODE_OFF;
                act_duty[i] <= '0;
            end
        end else if (boundary) begin
            for (int i = 0; i < N_LEDS; i++) begin
                act_mode[i] <= sh_mode[i];
                act_duty[i] <= sh_duty[i];
            end
        end
    end

    // Blink phase flips every BLINK_PERIODS PWM periods.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (boundary) begin
            if (blink_cnt == BLK_W'(BLINK_PERIODS - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

`ifdef LED_BREATHE_EN
    typedef enum logic {RAMP_UP, RAMP_DOWN} ramp_t;

    ramp_t               ramp;
    ramp_t               ramp_next;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_next;

    // Breathe ramp state advances once per PWM period.
    always_ff @(posedge clk) begin
        if (rst) begin
            ramp  <= RAMP_UP;
            level <= '0;
        end else if (boundary) begin
            ramp  <= ramp_next;
            level <= level_next;
        end
    end

    // Triangle ramp: turn around at the endpoints without repeating them.
    always_comb begin
        ramp_next  = ramp;
        level_next = level;
        case (ramp)
            RAMP_UP: begin
                if (level == DUTY_MAX) begin
                    ramp_next  = RAMP_DOWN;
                    level_next = level - 1'b1;
                end else begin
                    level_next = level + 1'b1;
                end
            end
            RAMP_DOWN: begin
                if (level == '0) begin
                    ramp_next  = RAMP_UP;
                    level_next = level + 1'b1;
                end else begin
                    level_next = level - 1'b1;
                end
            end
            default: ;
        endcase
    end
`endif

    // Effective duty per channel; depends only on registers that change at boundaries.
    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            eff[i] = '0;
            case (act_mode[i])
                MODE_OFF:   eff[i] = '0;
                MODE_ON:    eff[i] = act_duty[i];
                MODE_BLINK: eff[i] = blink_phase ? act_duty[i] : '0;
`ifdef LED_BREATHE_EN
                MODE_BREATHE: eff[i] = (act_duty[i] < level) ? act_duty[i] : level;
`else
                MODE_BREATHE: eff[i] = act_duty[i];
`endif
                default:    eff[i] = '0;
            endcase
        end
    end

    // Registered outputs; full-scale duty is forced on for the whole period.
    always_ff @(posedge clk) begin
        if (rst) begin
            led          <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            for (int i = 0; i < N_LEDS; i++) begin
                led[i] <= (eff[i] == DUTY_MAX) || (pwm_cnt < eff[i]);
            end
        end
    end
endmodule

// File: tb/tb_led_pwm_bank.sv
// tb/tb_led_pwm_bank.sv - directed bench for led_pwm_bank
module tb_led_pwm_bank;
    localparam int N_LEDS        = 5;
    localparam int PWM_BITS      = 4;
    localparam int PRESCALE      = 0;
    localparam int BLINK_PERIODS = 2;

    logic              clk;
    logic              rst;
    logic [N_LEDS-1:0] led;
    logic              period_start;

    int checks   = 0;
    int failures = 0;
    int on_cnt [N_LEDS];
    int n;
    int seen;
    int run_a;
    int run_b;
    int lvl;
    int expv;
    bit up;

    led_pwm_bank_if #(.N_LEDS(N_LEDS), .PWM_BITS(PWM_BITS)) wr_if ();

    led_pwm_bank #(
        .N_LEDS(N_LEDS),
        .PWM_BITS(PWM_BITS),
        .PRESCALE(PRESCALE),
        .BLINK_PERIODS(BLINK_PERIODS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr(wr_if),
        .led(led),
        .period_start(period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; the write is captured by the next posedge.
    task automatic wr(input int ch, input int mode, input int duty);
        wr_if.wr_en   = 1'b1;
        wr_if.wr_ch   = 3'(ch);
        wr_if.wr_mode = 2'(mode);
        wr_if.wr_duty = 4'(duty);
        @(negedge clk);
        wr_if.wr_en   = 1'b0;
    endtask

    // Advance to the next negedge showing period_start; out = OR of led seen on the way.
    task automatic wait_ps(output int led_or);
        bit found;
        found  = 1'b0;
        led_or = 0;
        for (int g = 0; g < 64; g++) begin
            @(negedge clk);
            if (period_start) begin
                found = 1'b1;
                break;
            end
            led_or = led_or | int'(led);
        end
        if (!found) check("ps_timeout", 0, 1);
    endtask

    // From a period_start negedge, count high cycles per channel over one period.
    task automatic measure_period();
        for (int i = 0; i < N_LEDS; i++) on_cnt[i] = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            for (int i = 0; i < N_LEDS; i++) on_cnt[i] += int'(led[i]);
        end
    endtask

    // Length of the current constant run on led[3]; ends on the first changed sample.
    task automatic count_run(output int len);
        logic v;
        v   = led[3];
        len = 1;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (led[3] != v) break;
            len++;
        end
    endtask

    initial begin
        rst           = 1'b1;
        wr_if.wr_en   = 1'b0;
        wr_if.wr_ch   = '0;
        wr_if.wr_mode = '0;
        wr_if.wr_duty = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_led", int'(led), 0);
        check("reset_ps", int'(period_start), 0);

        rst = 1'b0;
        n = 0;
        for (int g = 0; g < 64; g++) begin
            @(negedge clk);
            n++;
            if (period_start) break;
        end
        check("first_ps_delay", n, 16);

        repeat (3) @(negedge clk);
        wr(0, 1, 4);
        wait_ps(seen);
        check("pre_boundary_led", seen, 0);
        measure_period();
        check("ch0_on4", on_cnt[0], 4);
        check("others_idle", on_cnt[1] + on_cnt[2] + on_cnt[3] + on_cnt[4], 0);

        wr(1, 1, 0);
        wr(2, 1, 15);
        wr(3, 2, 15);
        wr(7, 1, 15);
        wr(0, 1, 2);
        wr(0, 1, 9);
        wait_ps(seen);
        measure_period();
        check("ch0_last_write", on_cnt[0], 9);
        check("ch1_duty0", on_cnt[1], 0);
        check("ch2_duty15", on_cnt[2], 16);
        check("ch4_untouched", on_cnt[4], 0);

        count_run(n);
        count_run(run_a);
        count_run(run_b);
        check("blink_run_a", run_a, 32);
        check("blink_run_b", run_b, 32);

        wr(0, 1, 15);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_led", int'(led), 0);
        check("rst_mid_ps", int'(period_start), 0);
        rst = 1'b0;
        wr(4, 3, 8);
        wait_ps(seen);
        check("rst_discard", seen, 0);

        lvl = 0;
        up  = 1'b1;
        for (int k = 1; k <= 20; k++) begin
`ifdef LED_BREATHE_EN
            if (up) begin
                if (lvl == 15) begin
                    up  = 1'b0;
                    lvl = 14;
                end else begin
                    lvl++;
                end
            end else begin
                if (lvl == 0) begin
                    up  = 1'b1;
                    lvl = 1;
                end else begin
                    lvl--;
                end
            end
            expv = (lvl < 8) ? lvl : 8;
`else
            expv = 8;
`endif
            measure_period();
            check($sformatf("breathe_p%0d", k), on_cnt[4], expv);
            if (k == 1) check("post_rst_ch0", on_cnt[0] + on_cnt[2], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
